// File: rtl/cricket_pkg.sv
// Shared types for the innings controller: ball outcome codes, FSM states
// and the width/saturation limit of the innings run total.
package cricket_pkg;

   localparam int           RUN_W   = 10;
   localparam logic [9:0]   RUN_SAT = 10'd1023;

   typedef enum logic [3:0] {
      OC_DOT    = 4'd0,
      OC_ONE    = 4'd1,
      OC_TWO    = 4'd2,
      OC_THREE  = 4'd3,
      OC_FOUR   = 4'd4,
      OC_SIX    = 4'd6,
      OC_WICKET = 4'd8,
      OC_WIDE   = 4'd9
   } outcome_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READY  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/ball_outcome_decoder.sv
// Combinational map from a 4-bit random sample to a ball outcome, its run
// value and whether it counts as a legal ball and/or a wicket.
module ball_outcome_decoder
   import cricket_pkg::*;
(
   input  logic [3:0] rand_in,
   output outcome_t   code,
   output logic [2:0] run_val,
   output logic       is_legal,
   output logic       is_wicket
);

   always_comb begin
      code    = OC_DOT;
      run_val = 3'd0;
      case (rand_in)
         4'd1, 4'd2:        begin code = OC_WICKET; run_val = 3'd0; end
         4'd6, 4'd7, 4'd8:  begin code = OC_ONE;    run_val = 3'd1; end
         4'd9, 4'd10:       begin code = OC_TWO;    run_val = 3'd2; end
         4'd11:             begin code = OC_THREE;  run_val = 3'd3; end
         4'd12, 4'd13:      begin code = OC_FOUR;   run_val = 3'd4; end
         4'd14:             begin code = OC_SIX;    run_val = 3'd6; end
         4'd15:             begin code = OC_WIDE;   run_val = 3'd1; end
         default:           begin code = OC_DOT;    run_val = 3'd0; end
      endcase
   end

   assign is_legal  = (code != OC_WIDE);
   assign is_wicket = (code == OC_WICKET);

endmodule

// File: rtl/innings_controller.sv
// Sequences one innings: latches the LFSR sample on a bowl request, applies the
// decoded outcome one cycle later and stops at the over or wicket limit.
module innings_controller
   import cricket_pkg::*;
#(
   parameter int MAX_OVERS      = 20,
   parameter int MAX_WICKETS    = 10,
   parameter int BALLS_PER_OVER = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bowl_req,
   input  logic [3:0]       rand_in,
   output logic             bowl_ack,
   output logic [3:0]       outcome,
   output logic [RUN_W-1:0] runs,
   output logic [3:0]       wickets,
   output logic [4:0]       overs,
   output logic [2:0]       balls_in_over,
   output logic             busy,
   output logic             innings_done
);

   localparam logic [4:0] OVERS_LIM   = 5'(MAX_OVERS);
   localparam logic [3:0] WICKETS_LIM = 4'(MAX_WICKETS);
   localparam logic [3:0] BALLS_LIM   = 4'(BALLS_PER_OVER);

   state_t           state_reg, state_next;
   logic [3:0]       sample_reg, sample_next;
   logic [RUN_W-1:0] runs_reg, runs_next;
   logic [3:0]       wickets_reg, wickets_next;
   logic [4:0]       overs_reg, overs_next;
   logic [2:0]       balls_reg, balls_next;
   outcome_t         outcome_reg, outcome_next;
   logic             ack_reg, ack_next;

   outcome_t   dec_code;
   logic [2:0] dec_run;
   logic       dec_legal;
   logic       dec_wicket;

   ball_outcome_decoder u_decoder (
      .rand_in   (sample_reg),
      .code      (dec_code),
      .run_val   (dec_run),
      .is_legal  (dec_legal),
      .is_wicket (dec_wicket)
   );

   // Counter values as they would be after applying the latched ball.
   logic [RUN_W:0]   run_sum;
   logic [RUN_W-1:0] runs_upd;
   logic [3:0]       balls_inc;
   logic             over_end;
   logic [2:0]       balls_upd;
   logic [4:0]       overs_upd;
   logic [3:0]       wickets_upd;

   always_comb begin
      run_sum     = {1'b0, runs_reg} + {8'd0, dec_run};
      runs_upd    = (run_sum > {1'b0, RUN_SAT}) ? RUN_SAT : run_sum[RUN_W-1:0];
      balls_inc   = {1'b0, balls_reg} + 4'd1;
      over_end    = dec_legal && (balls_inc == BALLS_LIM);
      balls_upd   = !dec_legal ? balls_reg : (over_end ? 3'd0 : balls_inc[2:0]);
      overs_upd   = overs_reg + {4'd0, over_end};
      wickets_upd = wickets_reg + {3'd0, dec_wicket};
   end

   always_comb begin
      state_next   = state_reg;
      sample_next  = sample_reg;
      runs_next    = runs_reg;
      wickets_next = wickets_reg;
      overs_next   = overs_reg;
      balls_next   = balls_reg;
      outcome_next = outcome_reg;
      ack_next     = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               runs_next    = '0;
               wickets_next = '0;
               overs_next   = '0;
               balls_next   = '0;
               outcome_next = OC_DOT;
               state_next   = ST_READY;
            end
         end
         ST_READY: begin
            if (bowl_req) begin
               sample_next = rand_in;
               state_next  = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            runs_next    = runs_upd;
            wickets_next = wickets_upd;
            overs_next   = overs_upd;
            balls_next   = balls_upd;
            outcome_next = dec_code;
            ack_next     = 1'b1;
            state_next   = (wickets_upd == WICKETS_LIM || overs_upd == OVERS_LIM)
                           ? ST_DONE : ST_READY;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         sample_reg  <= '0;
         runs_reg    <= '0;
         wickets_reg <= '0;
         overs_reg   <= '0;
         balls_reg   <= '0;
         outcome_reg <= OC_DOT;
         ack_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sample_reg  <= sample_next;
         runs_reg    <= runs_next;
         wickets_reg <= wickets_next;
         overs_reg   <= overs_next;
         balls_reg   <= balls_next;
         outcome_reg <= outcome_next;
         ack_reg     <= ack_next;
      end
   end

   assign bowl_ack      = ack_reg;
   assign outcome       = outcome_reg;
   assign runs          = runs_reg;
   assign wickets       = wickets_reg;
   assign overs         = overs_reg;
   assign balls_in_over = balls_reg;
   assign busy          = (state_reg == ST_READY) || (state_reg == ST_UPDATE);
   assign innings_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_innings_controller.sv
// Drives two controllers (default limits and a one-over innings) with directed
// and random stimulus and checks them against an innings-level model.
module tb_innings_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       bowl_req = 1'b0;
   logic [3:0] rand_in = 4'd0;

   logic       ack_w   [2];
   logic [3:0] oc_w    [2];
   logic [9:0] runs_w  [2];
   logic [3:0] wk_w    [2];
   logic [4:0] ov_w    [2];
   logic [2:0] bl_w    [2];
   logic       busy_w  [2];
   logic       done_w  [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   innings_controller #(.MAX_OVERS(20), .MAX_WICKETS(10), .BALLS_PER_OVER(6)) dut0 (
      .clk(clk), .rst(rst), .start(start), .bowl_req(bowl_req), .rand_in(rand_in),
      .bowl_ack(ack_w[0]), .outcome(oc_w[0]), .runs(runs_w[0]), .wickets(wk_w[0]),
      .overs(ov_w[0]), .balls_in_over(bl_w[0]), .busy(busy_w[0]), .innings_done(done_w[0])
   );

   innings_controller #(.MAX_OVERS(1), .MAX_WICKETS(10), .BALLS_PER_OVER(6)) dut1 (
      .clk(clk), .rst(rst), .start(start), .bowl_req(bowl_req), .rand_in(rand_in),
      .bowl_ack(ack_w[1]), .outcome(oc_w[1]), .runs(runs_w[1]), .wickets(wk_w[1]),
      .overs(ov_w[1]), .balls_in_over(bl_w[1]), .busy(busy_w[1]), .innings_done(done_w[1])
   );

   // Innings model: phase 0 idle, 1 waiting for a ball, 2 ball in flight, 3 over.
   int lim_overs [2] = '{20, 1};
   int code_tab  [16] = '{0, 8, 8, 0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 4, 6, 9};
   int m_phase [2];
   int m_samp  [2];
   int m_runs  [2];
   int m_wk    [2];
   int m_ov    [2];
   int m_bl    [2];
   int m_oc    [2];
   int m_ack   [2];
   bit m_valid = 1'b0;
   int ball_no = 0;

   function automatic int run_of(input int code);
      if (code == 9) return 1;
      if (code == 8) return 0;
      return code;
   endfunction

   task automatic chk(input string name, input int k, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic s, input logic b, input logic [3:0] x);
      for (int k = 0; k < 2; k++) begin
         m_ack[k] = 0;
         if (r) begin
            m_phase[k] = 0; m_runs[k] = 0; m_wk[k] = 0; m_ov[k] = 0; m_bl[k] = 0; m_oc[k] = 0;
         end else if (m_phase[k] == 0 || m_phase[k] == 3) begin
            if (s) begin
               m_phase[k] = 1; m_runs[k] = 0; m_wk[k] = 0; m_ov[k] = 0; m_bl[k] = 0; m_oc[k] = 0;
            end
         end else if (m_phase[k] == 1) begin
            if (b) begin
               m_samp[k]  = int'(x);
               m_phase[k] = 2;
            end
         end else begin
            m_oc[k]   = code_tab[m_samp[k]];
            m_runs[k] = m_runs[k] + run_of(m_oc[k]);
            if (m_runs[k] > 1023) m_runs[k] = 1023;
            if (m_oc[k] != 9) begin
               m_bl[k]++;
               if (m_bl[k] == 6) begin
                  m_bl[k] = 0;
                  m_ov[k]++;
               end
            end
            if (m_oc[k] == 8) m_wk[k]++;
            m_ack[k]   = 1;
            m_phase[k] = (m_wk[k] == 10 || m_ov[k] == lim_overs[k]) ? 3 : 1;
         end
      end
      m_valid = 1'b1;
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         chk("bowl_ack", k, int'(ack_w[k]), m_ack[k]);
         chk("outcome", k, int'(oc_w[k]), m_oc[k]);
         chk("runs", k, int'(runs_w[k]), m_runs[k]);
         chk("wickets", k, int'(wk_w[k]), m_wk[k]);
         chk("overs", k, int'(ov_w[k]), m_ov[k]);
         chk("balls_in_over", k, int'(bl_w[k]), m_bl[k]);
         chk("busy", k, int'(busy_w[k]), (m_phase[k] == 1 || m_phase[k] == 2) ? 1 : 0);
         chk("innings_done", k, int'(done_w[k]), (m_phase[k] == 3) ? 1 : 0);
      end
      if (m_ack[0] == 1) begin
         ball_no++;
         $display("ball %0d: outcome=%0d runs=%0d wickets=%0d overs=%0d.%0d done=%0d",
                  ball_no, m_oc[0], m_runs[0], m_wk[0], m_ov[0], m_bl[0],
                  (m_phase[0] == 3) ? 1 : 0);
      end
   endtask

   // One clock: drive inputs, let the DUTs and model take the edge, compare mid-cycle.
   task automatic step(input logic r, input logic s, input logic b, input logic [3:0] x);
      rst = r; start = s; bowl_req = b; rand_in = x;
      @(posedge clk);
      model_update(r, s, b, x);
      @(negedge clk);
      if (m_valid) compare_all();
   endtask

   task automatic bowl(input logic [3:0] x);
      step(1'b0, 1'b0, 1'b1, x);
      step(1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic new_innings();
      step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b0, 4'd0);
   endtask

   initial begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0);
      chk("reset_runs", 0, int'(runs_w[0]), 0);
      chk("reset_busy", 0, int'(busy_w[0]), 0);
      chk("reset_done", 0, int'(done_w[0]), 0);
      step(1'b0, 1'b0, 1'b1, 4'd7);
      chk("idle_ignores_req", 0, int'(busy_w[0]), 0);

      // Single SIX from a fresh innings.
      step(1'b0, 1'b1, 1'b0, 4'd0);
      chk("start_busy", 0, int'(busy_w[0]), 1);
      bowl(4'd14);
      chk("six_ack", 0, int'(ack_w[0]), 1);
      chk("six_outcome", 0, int'(oc_w[0]), 6);
      chk("six_runs", 0, int'(runs_w[0]), 6);
      chk("six_balls", 0, int'(bl_w[0]), 1);

      // A full over of singles, then a wide.
      new_innings();
      for (int i = 0; i < 6; i++) bowl(4'd6);
      chk("over_runs", 0, int'(runs_w[0]), 6);
      chk("over_overs", 0, int'(ov_w[0]), 1);
      chk("over_balls", 0, int'(bl_w[0]), 0);
      chk("one_over_done", 1, int'(done_w[1]), 1);
      bowl(4'd15);
      chk("wide_runs", 0, int'(runs_w[0]), 7);
      chk("wide_balls", 0, int'(bl_w[0]), 0);
      chk("wide_outcome", 0, int'(oc_w[0]), 9);

      // All out, then a further request must not be acknowledged.
      new_innings();
      for (int i = 0; i < 10; i++) bowl(4'd1);
      chk("allout_wickets", 0, int'(wk_w[0]), 10);
      chk("allout_ack", 0, int'(ack_w[0]), 1);
      chk("allout_done", 0, int'(done_w[0]), 1);
      bowl(4'd1);
      chk("after_done_ack", 0, int'(ack_w[0]), 0);
      chk("after_done_wickets", 0, int'(wk_w[0]), 10);

      // Wicket on the last ball of a one-over innings.
      new_innings();
      for (int i = 0; i < 5; i++) bowl(4'd0);
      bowl(4'd2);
      chk("last_ball_wickets", 1, int'(wk_w[1]), 1);
      chk("last_ball_overs", 1, int'(ov_w[1]), 1);
      chk("last_ball_done", 1, int'(done_w[1]), 1);
      chk("last_ball_ack", 1, int'(ack_w[1]), 1);
      step(1'b0, 1'b0, 1'b0, 4'd0);
      chk("last_ball_single_ack", 1, int'(ack_w[1]), 0);

      // Wides with bowl_req held high: saturation and back-to-back throughput.
      new_innings();
      for (int i = 0; i < 2 * 1030; i++) step(1'b0, 1'b0, 1'b1, 4'd15);
      step(1'b0, 1'b0, 1'b0, 4'd0);
      chk("sat_runs", 0, int'(runs_w[0]), 1023);
      for (int i = 0; i < 10; i++) bowl(4'd1);
      chk("sat_hold_runs", 0, int'(runs_w[0]), 1023);
      step(1'b0, 1'b1, 1'b0, 4'd0);
      chk("restart_runs", 0, int'(runs_w[0]), 0);
      chk("restart_wickets", 0, int'(wk_w[0]), 0);
      chk("restart_busy", 0, int'(busy_w[0]), 1);

      // Reset while a ball is in flight.
      bowl(4'd14);
      step(1'b0, 1'b0, 1'b1, 4'd12);
      step(1'b1, 1'b0, 1'b1, 4'd12);
      chk("rst_update_ack", 0, int'(ack_w[0]), 0);
      chk("rst_update_runs", 0, int'(runs_w[0]), 0);
      chk("rst_update_busy", 0, int'(busy_w[0]), 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd14);
      chk("rst_req_ignored", 0, int'(busy_w[0]), 0);

      // Random play.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
              4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
